key_mode_ctrl: RTL and testbench

Converts the debounced, active-low button levels (mode_set, inc, dec) into clock-setting control. Sits directly downstream of the key debounce filter and upstream of the time counter/display logic. Maintains the setting-mode state machine (RUN → SET_HOUR → SET_MIN → SET_SEC → RUN) and emits single-cycle increment/decrement pulses with hold-to-auto-repeat. Returns to RUN automatically after an idle timeout.

---
 rtl/key_pkg.sv | 34 +++
 rtl/key_repeat.sv | 90 +++++++++
 rtl/key_mode_ctrl.sv | 112 +++++++++++
 tb/tb_key_mode_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and default timing constants for the clock-setting key path.
// Times are in clk100khz cycles.
package key_pkg;

    typedef enum logic [1:0] {
        RUN,
        SET_HOUR,
        SET_MIN,
        SET_SEC
    } mode_e;

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_FIRST,
        RPT_WAIT_HOLD,
        RPT_REPEAT
    } rpt_e;

    localparam int HOLD_DELAY_DEF    = 100000;
    localparam int REPEAT_PERIOD_DEF = 20000;
    localparam int IDLE_TIMEOUT_DEF  = 1000000;

    function automatic mode_e next_mode(input mode_e m);
        mode_e r;
        unique case (m)
            RUN:      r = SET_HOUR;
            SET_HOUR: r = SET_MIN;
            SET_MIN:  r = SET_SEC;
            default:  r = RUN;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/key_repeat.sv
// Edge detect plus hold-to-auto-repeat for one active-low key.
// Emits a registered one-cycle pulse on press, after HOLD_DELAY, then every REPEAT_PERIOD.
module key_repeat
    import key_pkg::*;
#(
    parameter int HOLD_DELAY    = HOLD_DELAY_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
    input  logic clk100khz,
    input  logic rst_n,
    input  logic key,
    input  logic enable,
    input  logic cancel,
    output logic pulse,
    output logic held
);

    localparam int CMAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_DELAY - 1);
    localparam logic [CW-1:0] RPT_LAST  = CW'(REPEAT_PERIOD - 1);

    rpt_e          state;
    rpt_e          state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          key_prev;
    logic          press;
    logic          pulse_nx;

    assign press = key_prev & ~key;
    assign held  = (state != RPT_IDLE);

    // cnt holds the number of edges since the last pulse, minus one
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pulse_nx = 1'b0;
        if (key || cancel || !enable) begin
            state_nx = RPT_IDLE;
            cnt_nx   = '0;
        end else begin
            unique case (state)
                RPT_IDLE: begin
                    if (press) begin
                        state_nx = RPT_FIRST;
                        cnt_nx   = '0;
                        pulse_nx = 1'b1;
                    end
                end
                RPT_FIRST: begin
                    state_nx = RPT_WAIT_HOLD;
                    cnt_nx   = cnt + 1'b1;
                end
                RPT_WAIT_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state_nx = RPT_REPEAT;
                        cnt_nx   = '0;
                        pulse_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: begin
                    if (cnt == RPT_LAST) begin
                        cnt_nx   = '0;
                        pulse_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk100khz or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RPT_IDLE;
            cnt      <= '0;
            key_prev <= 1'b0;
            pulse    <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            key_prev <= key;
            pulse    <= pulse_nx;
        end
    end

endmodule

// File: rtl/key_mode_ctrl.sv
// Setting-mode FSM, idle timeout and inc/dec pulse generation
// from debounced active-low Mode Set / Increase / Decrease levels.
module key_mode_ctrl
    import key_pkg::*;
#(
    parameter int HOLD_DELAY    = HOLD_DELAY_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF,
    parameter int IDLE_TIMEOUT  = IDLE_TIMEOUT_DEF
) (
    input  logic       clk100khz,
    input  logic       rst_n,
    input  logic       mode_set,
    input  logic       inc,
    input  logic       dec,
    output logic [1:0] mode,
    output logic       inc_pulse,
    output logic       dec_pulse
);

    localparam int TW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [TW-1:0] IDLE_LAST = TW'(IDLE_TIMEOUT - 1);

    mode_e         mode_q;
    mode_e         mode_nx;
    logic          mode_prev;
    logic          mode_press_q;
    logic [TW-1:0] idle_cnt;
    logic [TW-1:0] idle_nx;
    logic          in_set;
    logic          any_low;
    logic          both_low;
    logic          timeout;
    logic          rpt_cancel;
    logic          inc_p;
    logic          dec_p;
    logic          inc_held;
    logic          dec_held;
    logic          inc_go;
    logic          dec_go;

    assign mode       = mode_q;
    assign in_set     = (mode_q != RUN);
    assign any_low    = ~mode_set | ~inc | ~dec;
    assign both_low   = ~inc & ~dec;
    assign timeout    = in_set & ~any_low & ~mode_press_q & (idle_cnt == IDLE_LAST);
    assign rpt_cancel = both_low | timeout;

    key_repeat #(
        .HOLD_DELAY    (HOLD_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_inc (
        .clk100khz (clk100khz),
        .rst_n     (rst_n),
        .key       (inc),
        .enable    (in_set),
        .cancel    (rpt_cancel),
        .pulse     (inc_p),
        .held      (inc_held)
    );

    key_repeat #(
        .HOLD_DELAY    (HOLD_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_dec (
        .clk100khz (clk100khz),
        .rst_n     (rst_n),
        .key       (dec),
        .enable    (in_set),
        .cancel    (rpt_cancel),
        .pulse     (dec_p),
        .held      (dec_held)
    );

    // a mode advance swallows any inc/dec pulse launched on the same press edge
    assign inc_go = inc_p & ~dec_p & ~dec_held & in_set & ~mode_press_q;
    assign dec_go = dec_p & ~inc_p & ~inc_held & in_set & ~mode_press_q;

    always_comb begin
        mode_nx = mode_q;
        if (mode_press_q) begin
            mode_nx = next_mode(mode_q);
        end else if (timeout) begin
            mode_nx = RUN;
        end
    end

    always_comb begin
        idle_nx = idle_cnt + 1'b1;
        if (any_low || mode_press_q || timeout || !in_set) begin
            idle_nx = '0;
        end
    end

    always_ff @(posedge clk100khz or negedge rst_n) begin
        if (!rst_n) begin
            mode_q       <= RUN;
            mode_prev    <= 1'b0;
            mode_press_q <= 1'b0;
            idle_cnt     <= '0;
            inc_pulse    <= 1'b0;
            dec_pulse    <= 1'b0;
        end else begin
            mode_q       <= mode_nx;
            mode_prev    <= mode_set;
            mode_press_q <= mode_prev & ~mode_set;
            idle_cnt     <= idle_nx;
            inc_pulse    <= inc_go;
            dec_pulse    <= dec_go;
        end
    end

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Directed bench for key_mode_ctrl with a cycle-level reference model.
// Short timing parameters keep every scenario to a few hundred cycles.
module tb_key_mode_ctrl;

    localparam int H = 10;
    localparam int R = 4;
    localparam int T = 50;

    logic       clk100khz = 1'b0;
    logic       rst_n     = 1'b0;
    logic       mode_set  = 1'b1;
    logic       inc       = 1'b1;
    logic       dec       = 1'b1;
    logic [1:0] mode;
    logic       inc_pulse;
    logic       dec_pulse;

    int total = 0;
    int bad   = 0;

    key_mode_ctrl #(
        .HOLD_DELAY    (H),
        .REPEAT_PERIOD (R),
        .IDLE_TIMEOUT  (T)
    ) dut (
        .clk100khz (clk100khz),
        .rst_n     (rst_n),
        .mode_set  (mode_set),
        .inc       (inc),
        .dec       (dec),
        .mode      (mode),
        .inc_pulse (inc_pulse),
        .dec_pulse (dec_pulse)
    );

    always #5 clk100khz = ~clk100khz;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: key press times and arithmetic on elapsed edges
    int n        = 0;
    int m_mode   = 0;
    bit m_pm     = 0;
    bit pv_m     = 0;
    bit pv_k[2]  = '{0, 0};
    bit arm[2]   = '{0, 0};
    int pn[2]    = '{0, 0};
    bit sp[2]    = '{0, 0};
    bit nsp[2]   = '{0, 0};
    bit lv[2]    = '{1, 1};
    int last_act = 0;
    bit e_inc    = 0;
    bit e_dec    = 0;
    bit mp;
    bit chg;
    bit anylow;

    function automatic bit due(input int k);
        return (k == 0) || (k >= H && ((k - H) % R) == 0);
    endfunction

    always @(posedge clk100khz or negedge rst_n) begin
        if (!rst_n) begin
            n = 0; m_mode = 0; m_pm = 0; pv_m = 0;
            pv_k = '{0, 0}; arm = '{0, 0}; sp = '{0, 0};
            last_act = 0; e_inc = 0; e_dec = 0;
        end else begin
            lv[0]  = inc;
            lv[1]  = dec;
            anylow = !mode_set || !inc || !dec;
            e_inc  = sp[0] && !sp[1] && m_mode != 0 && !m_pm;
            e_dec  = sp[1] && !sp[0] && m_mode != 0 && !m_pm;
            for (int k = 0; k < 2; k++) begin
                if (lv[k]) arm[k] = 0;
                else if (!lv[0] && !lv[1]) arm[k] = 0;
                else if (pv_k[k] && m_mode != 0) begin
                    arm[k] = 1;
                    pn[k]  = n;
                end else if (m_mode == 0) arm[k] = 0;
                nsp[k] = arm[k] && due(n - pn[k]);
            end
            mp  = !mode_set && pv_m;
            chg = m_pm;
            if (chg) m_mode = (m_mode + 1) % 4;
            else if (m_mode != 0 && !anylow && (n - last_act) >= T) begin
                m_mode = 0;
                chg    = 1;
            end
            if (anylow || chg) last_act = n;
            m_pm = mp;
            sp   = nsp;
            pv_m = mode_set;
            pv_k = lv;
            n++;
        end
    end

    always @(negedge clk100khz) begin
        if (rst_n) begin
            chk("mode", int'(mode), m_mode);
            chk("inc_pulse", int'(inc_pulse), int'(e_inc));
            chk("dec_pulse", int'(dec_pulse), int'(e_dec));
            chk("excl", int'(inc_pulse & dec_pulse), 0);
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clk100khz);
    endtask

    task automatic tap_mode(input int exp_mode);
        mode_set = 1'b0;
        cyc(1);
        chk("tap_early", int'(mode), (exp_mode + 3) % 4);
        cyc(1);
        chk("tap_mode", int'(mode), exp_mode);
        cyc(1);
        mode_set = 1'b1;
        cyc(3);
    endtask

    task automatic tap1();
        mode_set = 1'b0;
        cyc(1);
        mode_set = 1'b1;
        cyc(3);
    endtask

    int cnt;
    int mask;
    int c;
    bit found;

    initial begin
        cyc(3);
        chk("rst_mode", int'(mode), 0);
        chk("rst_inc", int'(inc_pulse), 0);
        chk("rst_dec", int'(dec_pulse), 0);
        rst_n = 1'b1;
        cyc(2);

        // four mode taps walk the setting ring
        tap_mode(1);
        tap_mode(2);
        tap_mode(3);
        tap_mode(0);

        // SET_MIN, inc held 30 cycles
        tap_mode(1);
        tap_mode(2);
        cnt = 0; mask = 0;
        inc = 1'b0;
        for (int j = 0; j < 32; j++) begin
            @(negedge clk100khz);
            if (inc_pulse) begin cnt++; mask |= (1 << j); end
            if (j == 29) inc = 1'b1;
        end
        chk("hold_cnt", cnt, 6);
        chk("hold_mask", mask, 32'h0888_8802);
        cyc(6);

        // back to RUN, taps are consumed
        tap_mode(3);
        tap_mode(0);
        cnt = 0;
        inc = 1'b0; cyc(3); inc = 1'b1; cyc(3);
        dec = 1'b0; cyc(3); dec = 1'b1; cyc(3);
        chk("run_mode", int'(mode), 0);

        // inc held through reset release
        inc = 1'b0;
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(3);
        tap_mode(1);
        for (int j = 0; j < 15; j++) begin
            @(negedge clk100khz);
            if (inc_pulse) cnt++;
        end
        chk("run_nopulse", cnt, 0);
        inc = 1'b1; cyc(2);
        inc = 1'b0; cyc(1);
        chk("repress0", int'(inc_pulse), 0);
        cyc(1);
        chk("repress1", int'(inc_pulse), 1);
        inc = 1'b1; cyc(3);

        // SET_HOUR, dec joins an inc hold
        cnt = 0; mask = 0;
        inc = 1'b0;
        for (int j = 0; j < 36; j++) begin
            @(negedge clk100khz);
            if (inc_pulse || dec_pulse) begin cnt++; mask |= (1 << j); end
            if (j == 11) dec = 1'b0;
            if (j == 20) dec = 1'b1;
        end
        chk("both_cnt", cnt, 2);
        chk("both_mask", mask, 32'h0000_0802);
        inc = 1'b1; cyc(2);
        inc = 1'b0; cyc(2);
        chk("both_repress", int'(inc_pulse), 1);
        inc = 1'b1; cyc(3);

        // idle timeout from SET_SEC entry
        tap1();
        chk("to_min", int'(mode), 2);
        mode_set = 1'b0; cyc(1); mode_set = 1'b1;
        cyc(1);
        chk("to_entry", int'(mode), 3);
        c = 0; found = 0;
        for (int j = 1; j <= 120 && !found; j++) begin
            @(negedge clk100khz);
            if (mode == 2'd0) begin found = 1; c = j; end
        end
        chk("to_found", int'(found), 1);
        chk("to_cycles", c, 50);

        // a press at cycle 49 restarts the timeout
        cyc(2);
        mode_set = 1'b0; cyc(1); mode_set = 1'b1;
        cyc(1);
        chk("to2_entry", int'(mode), 1);
        c = 0; found = 0;
        for (int j = 1; j <= 150 && !found; j++) begin
            @(negedge clk100khz);
            if (j == 48) inc = 1'b0;
            if (j == 49) inc = 1'b1;
            if (mode == 2'd0) begin found = 1; c = j; end
        end
        chk("to2_found", int'(found), 1);
        chk("to2_cycles", c, 99);
        cyc(2);

        // mode_set and inc together in SET_HOUR
        tap1();
        chk("sim_pre", int'(mode), 1);
        mode_set = 1'b0; inc = 1'b0;
        cyc(1);
        mode_set = 1'b1;
        chk("sim_early", int'(mode), 1);
        cyc(1);
        chk("sim_mode", int'(mode), 2);
        chk("sim_nopulse", int'(inc_pulse), 0);

        // asynchronous reset during a repeat pulse
        found = 0;
        for (int j = 0; j < 30 && !found; j++) begin
            @(negedge clk100khz);
            if (inc_pulse) found = 1;
        end
        chk("rpt_found", int'(found), 1);
        #2;
        chk("pre_rst_mode", int'(mode), 2);
        rst_n = 1'b0;
        #1;
        chk("arst_mode", int'(mode), 0);
        chk("arst_inc", int'(inc_pulse), 0);
        chk("arst_dec", int'(dec_pulse), 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        tap1();
        cnt = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk100khz);
            if (inc_pulse) cnt++;
        end
        chk("post_rst_held", cnt, 0);
        inc = 1'b1;
        cyc(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
